dest_hazard_ctrl: RTL and testbench

DEST_HAZARD_CTRL -- requirements
Module: dest_hazard_ctrl

---
 rtl/dest_hazard_ctrl_pkg.sv | 32 +++
 rtl/dest_hazard_ctrl_if.sv | 35 +++
 rtl/dest_hazard_ctrl_hazard_entry_cmp.sv | 15 +
 rtl/dest_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_dest_hazard_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/dest_hazard_ctrl_pkg.sv
// Shared types for the destination-register hazard controller: RegDst and
// forward-select encodings, FSM state, and the default register-address width.
package dest_hazard_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    REGDST_RT   = 2'd0,
    REGDST_RD   = 2'd1,
    REGDST_LINK = 2'd2
  } regdst_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_e;

  // The younger producer (EX at issue, MEM once the consumer reaches EX) wins.
  function automatic fwd_sel_e fwd_pick(input logic used, input logic m_ex,
                                        input logic m_mem);
    if (used && m_ex)  return FWD_MEM;
    if (used && m_mem) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/dest_hazard_ctrl_if.sv
// Decode-stage fields in, interlock and forward controls out; the controller
// owns the slave side.
interface dest_hazard_ctrl_if
  import dest_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [1:0]        RegDst;
  logic              RegWrite;
  logic              MemRead;
  logic              use_rs;
  logic              use_rt;
  logic              stall;
  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
  logic [1:0]        fwdA;
  logic [1:0]        fwdB;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, rs, rt, rd, RegDst, RegWrite, MemRead, use_rs, use_rt,
    input  stall, pc_write, ifid_write, idex_bubble, fwdA, fwdB, stall_cnt
  );

  modport slave (
    input  id_valid, rs, rt, rd, RegDst, RegWrite, MemRead, use_rs, use_rt,
    output stall, pc_write, ifid_write, idex_bubble, fwdA, fwdB, stall_cnt
  );
endinterface

// File: rtl/dest_hazard_ctrl_hazard_entry_cmp.sv
// Match comparator between one shadow-pipeline entry and one source register;
// register 0 is hard-wired and never matches.
module hazard_entry_cmp
  import dest_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              e_valid,
  input  logic              e_wr,
  input  logic [ADDR_W-1:0] e_dest,
  input  logic [ADDR_W-1:0] src,
  output logic              match
);
  assign match = e_valid && e_wr && (e_dest == src) && (src != '0);
endmodule

// File: rtl/dest_hazard_ctrl.sv
// Decode-stage interlock with a three-entry shadow pipeline (EX/MEM/WB).
// Optional FWD_PATH_EN: forwarding from MEM/WB, only load-use stalls remain.
module dest_hazard_ctrl
  import dest_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  dest_hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              wr;
    logic              ld;
  } entry_t;

  entry_t            ex, mem, wb;
  logic [ADDR_W-1:0] dec_dest;
  logic              m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
  logic              src_rs, src_rt;
  logic              hazard, stall;
  state_e            state_q, state_d;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt_q;
  logic              wb_unused;

  assign dec_dest = (bus.RegDst == REGDST_RT) ? bus.rt : bus.rd;
  assign src_rs   = bus.id_valid && bus.use_rs;
  assign src_rt   = bus.id_valid && bus.use_rt;

  hazard_entry_cmp #(.ADDR_W(ADDR_W)) u_cmp_ex_rs (
    .e_valid(ex.valid), .e_wr(ex.wr), .e_dest(ex.dest), .src(bus.rs), .match(m_ex_rs));
  hazard_entry_cmp #(.ADDR_W(ADDR_W)) u_cmp_ex_rt (
    .e_valid(ex.valid), .e_wr(ex.wr), .e_dest(ex.dest), .src(bus.rt), .match(m_ex_rt));
  hazard_entry_cmp #(.ADDR_W(ADDR_W)) u_cmp_mem_rs (
    .e_valid(mem.valid), .e_wr(mem.wr), .e_dest(mem.dest), .src(bus.rs), .match(m_mem_rs));
  hazard_entry_cmp #(.ADDR_W(ADDR_W)) u_cmp_mem_rt (
    .e_valid(mem.valid), .e_wr(mem.wr), .e_dest(mem.dest), .src(bus.rt), .match(m_mem_rt));

`ifdef FWD_PATH_EN
  logic [1:0] fwd_a_q, fwd_b_q;

  assign hazard = ex.ld && ((src_rs && m_ex_rs) || (src_rt && m_ex_rt));

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_pick(src_rs, m_ex_rs, m_mem_rs);
      fwd_b_q <= fwd_pick(src_rt, m_ex_rt, m_mem_rt);
    end
  end

  assign bus.fwdA = fwd_a_q;
  assign bus.fwdB = fwd_b_q;
`else
  // The register file writes before it reads, so a producer in WB is already visible.
  assign hazard   = (src_rs && (m_ex_rs || m_mem_rs)) || (src_rt && (m_ex_rt || m_mem_rt));
  assign bus.fwdA = FWD_RF;
  assign bus.fwdB = FWD_RF;
`endif

  assign stall           = hazard && !reset;
  assign bus.stall       = stall;
  assign bus.pc_write    = !stall;
  assign bus.ifid_write  = !stall;
  assign bus.idex_bubble = stall;
  assign bus.stall_cnt   = cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would let MEM see this edge's EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      wb  <= mem;
      mem <= ex;
      if (stall) begin
        ex.valid <= 1'b0;
      end else begin
        ex <= '{valid: bus.id_valid, dest: dec_dest, wr: bus.RegWrite, ld: bus.MemRead};
      end
    end
  end

  // WB is kept for observability only; nothing downstream consumes it.
  assign wb_unused = ^wb;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (stall)  state_d = S_STALL;
      S_STALL: if (!stall) state_d = S_RUN;
    endcase
  end

  always_comb begin
    cnt_en = 1'b0;
    if (state_q == S_STALL) cnt_en = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)                     cnt_q <= '0;
    else if (cnt_en && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_dest_hazard_ctrl.sv
// Self-checking bench for dest_hazard_ctrl; expectations follow FWD_PATH_EN.
// A second instance with a 2-bit counter exercises saturation.
module tb_dest_hazard_ctrl;
  import dest_hazard_ctrl_pkg::*;

`ifdef FWD_PATH_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic       id_valid;
    logic [4:0] rs, rt, rd;
    logic [1:0] regdst;
    logic       regwrite, memread, use_rs, use_rt;
    logic       exp_stall;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  logic clk = 1'b0;
  logic reset, sat_reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  dest_hazard_ctrl_if #(.ADDR_W(5), .CNT_W(16)) bus ();
  dest_hazard_ctrl_if #(.ADDR_W(5), .CNT_W(2))  sat_bus ();

  dest_hazard_ctrl #(.ADDR_W(5), .CNT_W(16)) u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
  dest_hazard_ctrl #(.ADDR_W(5), .CNT_W(2))  u_sat (.clk(clk), .reset(sat_reset), .bus(sat_bus.slave));

  assign sat_bus.id_valid = bus.id_valid;
  assign sat_bus.rs       = bus.rs;
  assign sat_bus.rt       = bus.rt;
  assign sat_bus.rd       = bus.rd;
  assign sat_bus.RegDst   = bus.RegDst;
  assign sat_bus.RegWrite = bus.RegWrite;
  assign sat_bus.MemRead  = bus.MemRead;
  assign sat_bus.use_rs   = bus.use_rs;
  assign sat_bus.use_rt   = bus.use_rt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t ins(input logic [4:0] rs, rt, rd, input logic [1:0] sel,
                               input logic wr, ld, urs, urt, es,
                               input logic [1:0] fa, fb);
    vec_t v;
    v.id_valid = 1'b1; v.rs = rs; v.rt = rt; v.rd = rd; v.regdst = sel;
    v.regwrite = wr; v.memread = ld; v.use_rs = urs; v.use_rt = urt;
    v.exp_stall = es; v.exp_fa = fa; v.exp_fb = fb;
    return v;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = ins(5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD_RF, FWD_RF);
    v.id_valid = 1'b0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus.id_valid = v.id_valid; bus.rs = v.rs; bus.rt = v.rt; bus.rd = v.rd;
    bus.RegDst = v.regdst; bus.RegWrite = v.regwrite; bus.MemRead = v.memread;
    bus.use_rs = v.use_rs; bus.use_rt = v.use_rt;
  endtask

  // Control outputs are combinational: check mid-cycle. Forward selects are
  // registered at issue: pop the expectation once the edge has passed.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    apply(v);
    exp_q.push_back(v);
    #1;
    check($sformatf("ctl[%0d]", idx),
          {28'd0, bus.stall, bus.pc_write, bus.ifid_write, bus.idex_bubble},
          {28'd0, v.exp_stall, !v.exp_stall, !v.exp_stall, v.exp_stall});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("fwd[%0d]", idx), {28'd0, bus.fwdA, bus.fwdB}, {28'd0, e.exp_fa, e.exp_fb});
  endtask

  task automatic push_idle(input int n);
    repeat (n) vecs.push_back(idle());
  endtask

  // lw $8,0($2) ; add $9,$8,$2
  task automatic push_lw_add();
    vecs.push_back(ins(5'd2, 5'd8, 5'd0, REGDST_RT, 1, 1, 1, 0, 0, FWD_RF, FWD_RF));
    repeat (FWD ? 1 : 2)
      vecs.push_back(ins(5'd8, 5'd2, 5'd9, REGDST_RD, 1, 0, 1, 1, 1, FWD_RF, FWD_RF));
    vecs.push_back(ins(5'd8, 5'd2, 5'd9, REGDST_RD, 1, 0, 1, 1, 0,
                       FWD ? FWD_WB : FWD_RF, FWD_RF));
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    reset = 1'b1;
    sat_reset = 1'b1;
    apply(idle());
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", {28'd0, bus.stall, bus.pc_write, bus.ifid_write, bus.idex_bubble}, 32'b0110);
    check("rst_fwd", {28'd0, bus.fwdA, bus.fwdB}, 32'd0);
    check("rst_cnt", bus.stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sat_reset = 1'b0;
    #1;
    check("post_rst_ctl", {28'd0, bus.stall, bus.pc_write, bus.ifid_write, bus.idex_bubble}, 32'b0110);
    check("post_rst_state", {31'd0, u_dut.state_q}, {31'd0, S_RUN});

    // load-use
    push_lw_add();
    push_idle(3);
    // add $8,$1,$2 ; sub $10,$8,$8
    vecs.push_back(ins(5'd1, 5'd2, 5'd8, REGDST_RD, 1, 0, 1, 1, 0, FWD_RF, FWD_RF));
    repeat (FWD ? 0 : 2)
      vecs.push_back(ins(5'd8, 5'd8, 5'd10, REGDST_RD, 1, 0, 1, 1, 1, FWD_RF, FWD_RF));
    vecs.push_back(ins(5'd8, 5'd8, 5'd10, REGDST_RD, 1, 0, 1, 1, 0,
                       FWD ? FWD_MEM : FWD_RF, FWD ? FWD_MEM : FWD_RF));
    push_idle(3);
    // writer of $0 then reader of $0
    vecs.push_back(ins(5'd1, 5'd2, 5'd0, REGDST_RD, 1, 0, 1, 1, 0, FWD_RF, FWD_RF));
    vecs.push_back(ins(5'd0, 5'd0, 5'd5, REGDST_RD, 0, 0, 1, 1, 0, FWD_RF, FWD_RF));
    push_idle(3);
    // same writer with RegDst=RT, rt=8, then reader of $8
    vecs.push_back(ins(5'd1, 5'd8, 5'd0, REGDST_RT, 1, 0, 1, 0, 0, FWD_RF, FWD_RF));
    repeat (FWD ? 0 : 2)
      vecs.push_back(ins(5'd8, 5'd3, 5'd12, REGDST_RD, 1, 0, 1, 1, 1, FWD_RF, FWD_RF));
    vecs.push_back(ins(5'd8, 5'd3, 5'd12, REGDST_RD, 1, 0, 1, 1, 0,
                       FWD ? FWD_MEM : FWD_RF, FWD_RF));
    push_idle(3);
    // qualifiers: use flags clear, then id_valid clear
    vecs.push_back(ins(5'd2, 5'd8, 5'd0, REGDST_RT, 1, 1, 1, 0, 0, FWD_RF, FWD_RF));
    vecs.push_back(ins(5'd8, 5'd8, 5'd13, REGDST_RD, 1, 0, 0, 0, 0, FWD_RF, FWD_RF));
    v = ins(5'd8, 5'd8, 5'd14, REGDST_RD, 1, 0, 1, 1, 0, FWD_RF, FWD_RF);
    v.id_valid = 1'b0;
    vecs.push_back(v);
    push_idle(3);
    // LINK selects rd; consumer one slot behind reads rt from MEM
    vecs.push_back(ins(5'd1, 5'd2, 5'd11, REGDST_LINK, 1, 0, 1, 1, 0, FWD_RF, FWD_RF));
    push_idle(1);
    repeat (FWD ? 0 : 1)
      vecs.push_back(ins(5'd4, 5'd11, 5'd14, REGDST_RD, 1, 0, 1, 1, 1, FWD_RF, FWD_RF));
    vecs.push_back(ins(5'd4, 5'd11, 5'd14, REGDST_RD, 1, 0, 1, 1, 0,
                       FWD_RF, FWD ? FWD_WB : FWD_RF));
    push_idle(3);
    // producer already in WB: never a hazard, never forwarded
    vecs.push_back(ins(5'd1, 5'd2, 5'd15, REGDST_RD, 1, 0, 1, 1, 0, FWD_RF, FWD_RF));
    push_idle(2);
    vecs.push_back(ins(5'd15, 5'd4, 5'd16, REGDST_RD, 1, 0, 1, 1, 0, FWD_RF, FWD_RF));
    push_idle(3);
    run_table();

    check("cnt_after_table", bus.stall_cnt, FWD ? 32'd1 : 32'd7);
    check("sat_after_table", {30'd0, sat_bus.stall_cnt}, FWD ? 32'd1 : 32'd3);

    // reset pulsed during the first load-use stall cycle
    @(negedge clk);
    apply(ins(5'd2, 5'd8, 5'd0, REGDST_RT, 1, 1, 1, 0, 0, FWD_RF, FWD_RF));
    @(negedge clk);
    apply(ins(5'd8, 5'd2, 5'd9, REGDST_RD, 1, 0, 1, 1, 0, FWD_RF, FWD_RF));
    #1;
    check("rst_mid_pre_stall", {31'd0, bus.stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_hold_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_post_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_mid_entries", {29'd0, u_dut.ex.valid, u_dut.mem.valid, u_dut.wb.valid}, 32'd0);
    check("rst_mid_state", {31'd0, u_dut.state_q}, {31'd0, S_RUN});
    check("rst_mid_cnt", bus.stall_cnt, 32'd0);
    check("rst_mid_fwd", {28'd0, bus.fwdA, bus.fwdB}, 32'd0);
    push_idle(3);
    run_table();
    check("rst_mid_cnt_later", bus.stall_cnt, 32'd0);

    // saturation: enough load-use stalls to overflow a 2-bit counter
    repeat (5) begin
      push_lw_add();
      push_idle(2);
    end
    push_idle(2);
    run_table();
    check("cnt_after_pairs", bus.stall_cnt, FWD ? 32'd5 : 32'd10);
    check("sat_saturated", {30'd0, sat_bus.stall_cnt}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
